// File: rtl/axi4_lite_queued_write_master.sv
// Queued AXI4-Lite write master: request FIFO feeding independent AW/W channels, one outstanding write.
// Define AXI4_LITE_WR_ERR_CNT_EN to enable the saturating non-OKAY response counter on err_count.
module axi4_lite_queued_write_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_start,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [STRB_WIDTH-1:0] write_strobe,
    output logic                  write_ready,
    output logic                  write_busy,
    output logic                  resp_valid,
    output logic [1:0]            resp_code,
    output logic                  resp_error,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ADDR_DATA  = 2'd1,
        ST_WAIT_BRESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic                  w_aw_pend_nxt;
    logic                  w_w_pend_nxt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_b_hs;
    logic                  w_not_empty;
    logic [ENT_W-1:0]      w_head;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_resp_valid;
    logic [1:0]            r_resp_code;
    logic                  r_resp_error;

    assign write_ready = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = write_start && write_ready;
    assign w_head      = r_mem[r_rd_ptr];

    // Request queue pointers and occupancy; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {write_addr, write_data, write_strobe};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, queue pop and per-channel pending flags
    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_b_hs        = 1'b0;
        w_aw_pend_nxt = r_aw_pend;
        w_w_pend_nxt  = r_w_pend;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_pop         = 1'b1;
                    w_aw_pend_nxt = 1'b1;
                    w_w_pend_nxt  = 1'b1;
                    w_state_nxt   = ST_ADDR_DATA;
                end
            end
            ST_ADDR_DATA: begin
                w_aw_pend_nxt = r_aw_pend && !M_AXI_AWREADY;
                w_w_pend_nxt  = r_w_pend && !M_AXI_WREADY;
                if (!w_aw_pend_nxt && !w_w_pend_nxt) w_state_nxt = ST_WAIT_BRESP;
            end
            ST_WAIT_BRESP: begin
                if (M_AXI_BVALID) begin
                    w_b_hs = 1'b1;
                    if (w_not_empty) begin
                        w_pop         = 1'b1;
                        w_aw_pend_nxt = 1'b1;
                        w_w_pend_nxt  = 1'b1;
                        w_state_nxt   = ST_ADDR_DATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Channel payload registers hold their last value after the handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_aw_pend <= w_aw_pend_nxt;
            r_w_pend  <= w_w_pend_nxt;
            if (w_pop) begin
                r_awaddr <= w_head[ENT_W-1 -: ADDR_WIDTH];
                r_wdata  <= w_head[STRB_WIDTH +: DATA_WIDTH];
                r_wstrb  <= w_head[STRB_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_code  <= 2'b00;
            r_resp_error <= 1'b0;
        end else begin
            r_resp_valid <= w_b_hs;
            r_resp_error <= w_b_hs && (M_AXI_BRESP != 2'b00);
            if (w_b_hs) r_resp_code <= M_AXI_BRESP;
        end
    end

`ifdef AXI4_LITE_WR_ERR_CNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= 8'h00;
        end else if (r_resp_valid && r_resp_error && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'h00;
`endif

    assign write_busy    = w_not_empty || (r_state != ST_IDLE);
    assign resp_valid    = r_resp_valid;
    assign resp_code     = r_resp_code;
    assign resp_error    = r_resp_error;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_aw_pend;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_w_pend;
    assign M_AXI_BREADY  = (r_state == ST_WAIT_BRESP);

endmodule

// File: tb/tb_axi4_lite_queued_write_master.sv
// Scoreboard bench for axi4_lite_queued_write_master: queued expectations, slave model and response monitor.
module tb_axi4_lite_queued_write_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

`ifdef AXI4_LITE_WR_ERR_CNT_EN
    localparam int EXP_ERR3   = 3;
    localparam int EXP_ERRSAT = 255;
`else
    localparam int EXP_ERR3   = 0;
    localparam int EXP_ERRSAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write_start = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [DW-1:0] write_data = '0;
    logic [SW-1:0] write_strobe = '0;
    logic          write_ready, write_busy, resp_valid, resp_error;
    logic [1:0]    resp_code;
    logic [7:0]    err_count;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY = 1'b0;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WVALID;
    logic          WREADY = 1'b0;
    logic [1:0]    BRESP = 2'b00;
    logic          BVALID = 1'b0;
    logic          BREADY;

    axi4_lite_queued_write_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_ready(write_ready), .write_busy(write_busy),
        .resp_valid(resp_valid), .resp_code(resp_code), .resp_error(resp_error),
        .err_count(err_count),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0]    exp_aw_q [$];
    logic [DW+SW-1:0] exp_w_q [$];
    logic [1:0]       exp_resp_q [$];
    logic [1:0]       bresp_plan [$];

    int aw_delay = 0, w_delay = 0;
    bit stall = 0, len_chk = 1, b2b_chk = 0;
    int aw_seen = 0, w_seen = 0, aw_len = 0, w_len = 0, aw_total = 0;
    bit aw_done = 0, w_done = 0, aw_wait = 0, w_wait = 0, b_drop = 0, prev_awvalid = 0;
    logic [AW-1:0]    aw_hold;
    logic [DW+SW-1:0] w_hold;
    int cyc = 0, last_b_cyc = -10, err_pulses = 0;
    logic [1:0] resp_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Slave model: READYs/BVALID decided at negedge; a handshake occurs at the next posedge when both are high
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
            aw_seen = 0; w_seen = 0; aw_len = 0; w_len = 0;
            aw_done = 0; w_done = 0; aw_wait = 0; w_wait = 0; b_drop = 0; prev_awvalid = 0;
            exp_aw_q.delete(); exp_w_q.delete(); bresp_plan.delete();
        end else begin
            if (b_drop) begin
                BVALID = 0; b_drop = 0;
            end else if (!BVALID && aw_done && w_done) begin
                aw_done = 0; w_done = 0; BVALID = 1;
                BRESP = (bresp_plan.size() != 0) ? bresp_plan.pop_front() : 2'b00;
            end
            if (BVALID && BREADY) begin b_drop = 1; last_b_cyc = cyc; end
            if (AWVALID || WVALID) chk("bready_during_addr_data", BREADY, 0);

            if (aw_wait) begin
                chk("awvalid_held", AWVALID, 1);
                if (AWVALID) chk("awaddr_stable", AWADDR, aw_hold);
            end
            AWREADY = !stall && (aw_seen >= aw_delay);
            if (AWVALID) begin
                aw_len++; aw_total++;
                if (AWREADY) begin
                    if (exp_aw_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL aw_unexpected: addr 0x%0h issued, none required", AWADDR);
                    end else chk("aw_addr", AWADDR, exp_aw_q.pop_front());
                    if (len_chk) chk("aw_valid_cycles", aw_len, aw_delay + 1);
                    aw_done = 1; aw_seen = 0; aw_len = 0; aw_wait = 0;
                end else begin
                    aw_seen++; aw_wait = 1; aw_hold = AWADDR;
                end
            end else aw_wait = 0;
            if (b2b_chk && AWVALID && !prev_awvalid) chk("b2b_no_bubble", cyc, last_b_cyc + 1);
            prev_awvalid = AWVALID;

            if (w_wait) begin
                chk("wvalid_held", WVALID, 1);
                if (WVALID) chk("wdata_stable", {WDATA, WSTRB}, w_hold);
            end
            WREADY = !stall && (w_seen >= w_delay);
            if (WVALID) begin
                w_len++;
                if (WREADY) begin
                    if (exp_w_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL w_unexpected: data 0x%0h issued, none required", WDATA);
                    end else chk("w_data_strb", {WDATA, WSTRB}, exp_w_q.pop_front());
                    if (len_chk) chk("wvalid_cycles", w_len, w_delay + 1);
                    w_done = 1; w_seen = 0; w_len = 0; w_wait = 0;
                end else begin
                    w_seen++; w_wait = 1; w_hold = {WDATA, WSTRB};
                end
            end else w_wait = 0;
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_resp_q.delete();
        end else if (resp_valid) begin
            if (exp_resp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL resp_unexpected: code 0x%0h, no response required", resp_code);
            end else begin
                resp_e = exp_resp_q.pop_front();
                chk("resp_code", resp_code, resp_e);
                chk("resp_error", resp_error, resp_e != 2'b00);
            end
            if (resp_error) err_pulses++;
        end
    end

    // Called at a negedge; drives one push cycle and returns at the next negedge
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [1:0] br, input bit exp_acc);
        write_start = 1; write_addr = a; write_data = d; write_strobe = s;
        chk("write_ready_at_push", write_ready, exp_acc);
        if (exp_acc) begin
            exp_aw_q.push_back(a); exp_w_q.push_back({d, s});
            exp_resp_q.push_back(br); bresp_plan.push_back(br);
        end
        @(negedge clk);
        write_start = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_resp_q.size() != 0 || write_busy) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, n);
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int e0, a0;
        repeat (3) @(negedge clk);
        chk("rst_write_ready", write_ready, 1);
        chk("rst_write_busy", write_busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_resp_code", resp_code, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_wstrb", WSTRB, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Single write, latency
        chk("t1_busy_before", write_busy, 0);
        push(32'h1000, 32'hDEADBEEF, 4'hF, 2'b00, 1);
        chk("t1_busy_n1", write_busy, 1);
        chk("t1_awvalid_n1", AWVALID, 0);
        @(negedge clk);
        chk("t1_awvalid_n2", AWVALID, 1);
        chk("t1_wvalid_n2", WVALID, 1);
        chk("t1_awaddr_n2", AWADDR, 32'h1000);
        chk("t1_wdata_n2", WDATA, 32'hDEADBEEF);
        chk("t1_wstrb_n2", WSTRB, 4'hF);
        chk("t1_bready_n2", BREADY, 0);
        @(negedge clk);
        chk("t1_bready_n3", BREADY, 1);
        chk("t1_awvalid_n3", AWVALID, 0);
        chk("t1_resp_valid_n3", resp_valid, 0);
        @(negedge clk);
        chk("t1_resp_valid_n4", resp_valid, 1);
        chk("t1_busy_n4", write_busy, 0);
        wait_idle("t1");

        // AW late, then W late
        aw_delay = 3; w_delay = 0;
        push(32'h2000, 32'h1122_3344, 4'h3, 2'b00, 1);
        wait_idle("t2a");
        aw_delay = 0; w_delay = 3;
        push(32'h2004, 32'h5566_7788, 4'hC, 2'b00, 1);
        wait_idle("t2b");
        w_delay = 0;

        // Full queue behind a stalled transaction, then back-to-back drain
        stall = 1; len_chk = 0;
        push(32'h3000, 32'hA0A0_0000, 4'hF, 2'b00, 1);
        repeat (3) @(negedge clk);
        push(32'h3004, 32'hA0A0_0001, 4'h1, 2'b00, 1);
        push(32'h3008, 32'hA0A0_0002, 4'h2, 2'b00, 1);
        push(32'h300C, 32'hA0A0_0003, 4'h4, 2'b00, 1);
        push(32'h3010, 32'hA0A0_0004, 4'h8, 2'b00, 1);
        push(32'h3014, 32'hA0A0_0005, 4'hF, 2'b00, 0);
        chk("t3_write_ready_full", write_ready, 0);
        chk("t3_busy_full", write_busy, 1);
        b2b_chk = 1; stall = 0;
        wait_idle("t3");
        b2b_chk = 0; len_chk = 1;

        // Error responses
        e0 = err_pulses;
        push(32'h4000, 32'h0000_0001, 4'hF, 2'b10, 1);
        push(32'h4004, 32'h0000_0002, 4'hF, 2'b00, 1);
        push(32'h4008, 32'h0000_0003, 4'hF, 2'b10, 1);
        push(32'h400C, 32'h0000_0004, 4'hF, 2'b10, 1);
        wait_idle("t4");
        repeat (2) @(negedge clk);
        chk("t4_error_pulses", err_pulses - e0, 3);
        chk("t4_err_count", err_count, EXP_ERR3);
        for (int i = 0; i < 300; i++) begin
            push(32'(32'h4100 + i * 4), 32'(i), 4'hF, 2'b10, 1);
            wait_idle("t4_sat");
        end
        repeat (2) @(negedge clk);
        chk("t4_err_count_sat", err_count, EXP_ERRSAT);

        // Reset mid-transaction with two queued entries
        stall = 1; len_chk = 0;
        push(32'h5000, 32'hBBBB_0000, 4'hF, 2'b00, 1);
        repeat (2) @(negedge clk);
        push(32'h5004, 32'hBBBB_0001, 4'hF, 2'b00, 1);
        push(32'h5008, 32'hBBBB_0002, 4'hF, 2'b00, 1);
        chk("t5_awvalid_before", AWVALID, 1);
        #2 rst = 1;
        #1;
        chk("t5_awvalid", AWVALID, 0);
        chk("t5_wvalid", WVALID, 0);
        chk("t5_bready", BREADY, 0);
        chk("t5_write_ready", write_ready, 1);
        chk("t5_write_busy", write_busy, 0);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_resp_code", resp_code, 0);
        chk("t5_err_count", err_count, 0);
        chk("t5_awaddr", AWADDR, 0);
        chk("t5_wdata", WDATA, 0);
        chk("t5_wstrb", WSTRB, 0);
        @(negedge clk);
        #2 rst = 0;
        stall = 0;
        a0 = aw_total;
        repeat (20) @(negedge clk);
        chk("t5_no_issue_after_rst", aw_total - a0, 0);
        chk("t5_busy_after_rst", write_busy, 0);
        len_chk = 1;

        // Recovery after reset
        push(32'h6000, 32'hCAFE_F00D, 4'h5, 2'b00, 1);
        wait_idle("t6");
        chk("end_aw_q_empty", exp_aw_q.size(), 0);
        chk("end_w_q_empty", exp_w_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
